// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU or load data, commits it to a 32-entry register file
// and serves two combinational read ports with same-cycle write-through bypass.
module wb_regfile #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    // Value retire_count takes in reset; nonzero only to exercise wrap in simulation.
    parameter logic [31:0] RETIRE_INIT = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_reg,
    input  logic                  write_back,
    input  logic [DATA_WIDTH-1:0] ALU_output,
    input  logic [DATA_WIDTH-1:0] readDataFromMemory,
    input  logic [ADDR_WIDTH-1:0] rt_or_rd,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [31:0]           retire_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [31:0]           retire_q, retire_d;
    logic                  commit;

    assign wb_data = write_back ? readDataFromMemory : ALU_output;

    // Index 0 is never written, so its storage stays zero; reads of it are forced to 0 anyway.
    assign commit = write_reg && (rt_or_rd != '0) && !rst;

    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) begin
            if (commit && (rs_addr == rt_or_rd)) begin
                rs_data = wb_data;
            end else begin
                rs_data = regs_q[rs_addr];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != '0) begin
            if (commit && (rt_addr == rt_or_rd)) begin
                rt_data = wb_data;
            end else begin
                rt_data = regs_q[rt_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[rt_or_rd] <= wb_data;
        end
    end

    always_comb begin
        retire_d = retire_q;
        if (commit) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= RETIRE_INIT;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset/wrap sequences and
// randomized traffic against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_reg, write_back;
    logic [31:0] ALU_output, readDataFromMemory;
    logic [4:0]  rt_or_rd, rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data, retire_count;
    logic [31:0] rs_data_w, rt_data_w, wb_data_w, retire_count_w;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .write_reg(write_reg), .write_back(write_back),
        .ALU_output(ALU_output), .readDataFromMemory(readDataFromMemory),
        .rt_or_rd(rt_or_rd), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
        .retire_count(retire_count)
    );

    // Second copy whose counter resets near the top, to observe the wrap cheaply.
    wb_regfile #(.RETIRE_INIT(32'hFFFF_FFFE)) dut_w (
        .clk(clk), .rst(rst), .write_reg(write_reg), .write_back(write_back),
        .ALU_output(ALU_output), .readDataFromMemory(readDataFromMemory),
        .rt_or_rd(rt_or_rd), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_w), .rt_data(rt_data_w), .wb_data(wb_data_w),
        .retire_count(retire_count_w)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain architectural state.
    logic [31:0] mregs [32];
    logic [31:0] mcnt;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic void mclear();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mcnt = '0;
    endfunction

    function automatic logic [31:0] mwb();
        return write_back ? readDataFromMemory : ALU_output;
    endfunction

    function automatic logic mcommit();
        return write_reg && (rt_or_rd != 0) && !rst;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (mcommit() && a == rt_or_rd) return mwb();
        return mregs[a];
    endfunction

    function automatic void check_model(input string tag);
        check({tag, ".rs"}, rs_data, mread(rs_addr));
        check({tag, ".rt"}, rt_data, mread(rt_addr));
        check({tag, ".wb"}, wb_data, mwb());
        check({tag, ".cnt"}, retire_count, mcnt);
        check({tag, ".cntw"}, retire_count_w, mcnt + 32'hFFFF_FFFE);
    endfunction

    task automatic drive(input logic r, input logic wr, input logic wbk, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] dst, input logic [4:0] ra,
                         input logic [4:0] rb);
        @(negedge clk);
        rst = r; write_reg = wr; write_back = wbk; ALU_output = alu;
        readDataFromMemory = mem; rt_or_rd = dst; rs_addr = ra; rt_addr = rb;
        if (r) mclear();
        #1;
    endtask

    task automatic edge_update();
        logic c;
        logic [31:0] v;
        c = mcommit();
        v = mwb();
        @(posedge clk);
        if (rst) mclear();
        else if (c) begin
            mregs[rt_or_rd] = v;
            mcnt = mcnt + 32'd1;
        end
        #1;
    endtask

    typedef struct packed {
        logic        wr;
        logic        wbk;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dst;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_wb;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h1234, 32'h0, 5'd3, 5'd3, 5'd0,
                   32'h1234, 32'h0, 32'h1234, 32'd0};
        tbl[1] = '{1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 5'd4, 5'd3, 5'd4,
                   32'h1234, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        tbl[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4,
                   32'h1234, 32'hDEADBEEF, 32'h0, 32'd2};
        tbl[3] = '{1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 5'd7,
                   32'h0, 32'h0, 32'hA5A5A5A5, 32'd2};
        tbl[4] = '{1'b1, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 5'd7,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd2};
        tbl[5] = '{1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd7,
                   32'h0, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'd3};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 32'd3};
        tbl[7] = '{1'b1, 1'b0, 32'h55, 32'h0, 5'd9, 5'd9, 5'd3,
                   32'h55, 32'h1234, 32'h55, 32'd3};

        // Reset held for two edges with a write pending: it must be lost.
        rst = 1'b1; write_reg = 1'b1; write_back = 1'b0; ALU_output = 32'h77;
        readDataFromMemory = 32'h0; rt_or_rd = 5'd5; rs_addr = 5'd5; rt_addr = 5'd5;
        mclear();
        repeat (2) @(posedge clk);
        #1;
        check("rst.wb_follows", wb_data, 32'h77);
        check("rst.rs_zero", rs_data, 32'h0);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(i));
            check("rst.reg", rs_data, 32'h0);
            edge_update();
        end
        check("rst.cnt", retire_count, 32'h0);
        check("rst.cntw", retire_count_w, 32'hFFFF_FFFE);

        for (int k = 0; k < 8; k++) begin
            drive(1'b0, tbl[k].wr, tbl[k].wbk, tbl[k].alu, tbl[k].mem, tbl[k].dst,
                  tbl[k].ra, tbl[k].rb);
            check($sformatf("vec%0d.rs", k), rs_data, tbl[k].e_rs);
            check($sformatf("vec%0d.rt", k), rt_data, tbl[k].e_rt);
            check($sformatf("vec%0d.wb", k), wb_data, tbl[k].e_wb);
            check($sformatf("vec%0d.cnt", k), retire_count, tbl[k].e_cnt);
            if (k == 2) check("wrap.zero", retire_count_w, 32'h0);
            edge_update();
        end
        check("r0.cnt_after", retire_count, 32'd4);

        // Asynchronous reset pulse between edges clears storage immediately.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd3);
        check("mid.pre_rs", rs_data, 32'h55);
        rst = 1'b1;
        mclear();
        #1;
        check("mid.rs", rs_data, 32'h0);
        check("mid.rt", rt_data, 32'h0);
        check("mid.cnt", retire_count, 32'h0);
        check("mid.cntw", retire_count_w, 32'hFFFF_FFFE);
        rst = 1'b0;
        #1;
        check("mid.rs_after", rs_data, 32'h0);
        edge_update();

        // First edge after release commits.
        drive(1'b0, 1'b1, 1'b0, 32'hCAFE, 32'h0, 5'd9, 5'd9, 5'd9);
        edge_update();
        check("rel.cnt", retire_count, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
        check("rel.rs", rs_data, 32'hCAFE);
        edge_update();

        for (int n = 0; n < 400; n++) begin
            logic [4:0] dst;
            dst = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), $urandom, $urandom, dst,
                  ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31)));
            check_model("rand");
            edge_update();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (ALU result or memory load data) and commits it to a 32-entry architectural register file.
- Serves the decode stage with two combinational read ports that include same-cycle write-through bypass.
- Keeps a committed-write counter for performance and debug visibility.

Parameters:
- DATA_WIDTH, 32, width of register data, ALU result and memory data.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_reg  input  1  MEM/WB control: commit the writeback value this cycle.
- write_back  input  1  MEM/WB control: 1 selects readDataFromMemory, 0 selects ALU_output.
- ALU_output  input  DATA_WIDTH  ALU result from MEM/WB.
- readDataFromMemory  input  DATA_WIDTH  load data from MEM/WB.
- rt_or_rd  input  ADDR_WIDTH  destination register index from MEM/WB.
- rs_addr  input  ADDR_WIDTH  decode read port A index.
- rt_addr  input  ADDR_WIDTH  decode read port B index.
- rs_data  output  DATA_WIDTH  read port A data, combinational.
- rt_data  output  DATA_WIDTH  read port B data, combinational.
- wb_data  output  DATA_WIDTH  selected writeback value, combinational, for forwarding.
- retire_count  output  32  number of committed register writes since reset.

Behaviour:
- wb_data = write_back ? readDataFromMemory : ALU_output. It is purely combinational and is driven regardless of write_reg.
- Commit condition: commit = write_reg && (rt_or_rd != 0) && !rst.
- On the clk rising edge with commit true: regs[rt_or_rd] <= wb_data. The value is architecturally visible in storage from the next cycle.
- Register 0 is hardwired to 0.
  - Writes to index 0 are dropped and do not count.
  - Reads of index 0 always return 0.
- Read port A:
  - If rs_addr == 0: return 0.
  - Else if commit && rs_addr == rt_or_rd: return wb_data (same-cycle bypass, zero-latency write-to-read).
  - Else: return regs[rs_addr].
- Read port B: identical rule using rt_addr.
- Both ports may read the same index, and may read the index being written. Both return the bypassed value.
- retire_count increments by 1 on every rising edge with commit true.
  - Wraps from 0xFFFFFFFF to 0x00000000; no saturation, no flag.
- Reset (asynchronous, immediate on rst rising, held while rst = 1):
  - All regs = 0; retire_count = 0.
  - rs_data = rt_data = 0, because storage is 0 and bypass is suppressed.
  - wb_data still follows its inputs.
- Reset mid-operation: a write presented in the same cycle rst is high is lost and not counted. No partial state survives.
- Reset release: the first commit can occur on the first rising edge with rst low.
- Latency:
  - Write: 1 clock to storage.
  - Read: 0 clocks, combinational, bypass included.
- No backpressure or stall input. Every cycle with write_reg = 1 and a non-zero destination commits.
- Unknown or X on write_reg outside reset is a bench error. The design takes no defined action for it.

Test Plan:
- Reset values: assert rst for 2 cycles with write_reg = 1, rt_or_rd = 5 → after release regs[1..31] read 0, retire_count = 0, regs[5] = 0.
- ALU vs memory select: cycle 1 write_reg = 1, write_back = 0, ALU_output = 0x1234, rt_or_rd = 3; cycle 2 write_back = 1, readDataFromMemory = 0xDEADBEEF, rt_or_rd = 4 → rs_addr = 3 reads 0x1234, rt_addr = 4 reads 0xDEADBEEF, retire_count = 2.
- Bypass: write_reg = 1, rt_or_rd = 7, ALU_output = 0xA5A5A5A5, rs_addr = rt_addr = 7 in the same cycle, before the edge → rs_data = rt_data = 0xA5A5A5A5. With write_reg = 0 and the same addresses → old value 0.
- Register 0: write 0xFFFFFFFF to index 0 with write_reg = 1, rs_addr = 0 → rs_data = 0 in that cycle and after, retire_count unchanged.
- Async reset mid-stream: commit 0x55 to r9, then pulse rst between clock edges → rs_addr = 9 reads 0 immediately, before the next edge, and retire_count = 0.
- Counter wrap: force retire_count to 0xFFFFFFFE via 2**32-2 commits (or bench preload), then 2 commits → retire_count = 0x00000000.
